// File: rtl/fm_core_scheduler.sv
// Round-robin scheduler time-multiplexing one fixed-latency FMCore among NUM_CH requesters.
// Define FM_SCHED_STATS_EN to add saturating per-channel grant and stall counters.
module fm_core_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CORE_LATENCY = 1,
  parameter int unsigned OUT_DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_enable,
  input  logic [NUM_CH-1:0]         req_valid,
  output logic [NUM_CH-1:0]         req_ready,
  input  logic [NUM_CH*DATA_W-1:0]  req_data,
  output logic [DATA_W-1:0]         core_in_value,
  input  logic [DATA_W-1:0]         core_out_value,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NUM_CH)-1:0] resp_ch,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy
`ifdef FM_SCHED_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]      stat_grants,
  output logic [15:0]               stat_stall
`endif
);

  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned InfW = $clog2(CORE_LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic [ChW-1:0] rr_q, rr_d;
  logic [DATA_W-1:0] core_in_q;

  // Stage 0 is aligned with core_in_value, stage CORE_LATENCY with core_out_value.
  logic [CORE_LATENCY:0] tag_vld_q;
  logic [ChW-1:0]        tag_ch_q [CORE_LATENCY+1];

  logic [ChW-1:0]    mem_ch_q   [OUT_DEPTH];
  logic [DATA_W-1:0] mem_data_q [OUT_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic [InfW-1:0] inflight;
  logic [31:0]     occ;
  logic            credit_ok;
  logic            found;
  logic [ChW-1:0]  win;
  logic            grant;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued sample owns a FIFO slot until popped, so pushes can never hit a full FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= CORE_LATENCY; i++) begin
      inflight = inflight + InfW'(tag_vld_q[i]);
    end
    occ       = 32'(fifo_cnt_q) + 32'(inflight);
    credit_ok = occ < OUT_DEPTH;
  end

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ChW'(idx);
      end
    end
  end

  assign grant     = (state_q == StRun) && credit_ok && found;
  assign req_ready = grant ? (NUM_CH'(1) << win) : '0;

  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (win == ChW'(NUM_CH - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_enable) state_d = StRun;
      StRun:   if (!cfg_enable) state_d = StDrain;
      StDrain: begin
        if (cfg_enable) begin
          state_d = StRun;
        end else if (inflight == '0 && fifo_cnt_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      core_in_q <= '0;
      tag_vld_q <= '0;
      for (int unsigned i = 0; i <= CORE_LATENCY; i++) begin
        tag_ch_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      core_in_q <= grant ? req_data[32'(win) * DATA_W +: DATA_W] : '0;
      tag_vld_q <= {tag_vld_q[CORE_LATENCY-1:0], grant};
      tag_ch_q[0] <= win;
      for (int unsigned i = 1; i <= CORE_LATENCY; i++) begin
        tag_ch_q[i] <= tag_ch_q[i-1];
      end
    end
  end

  assign push = tag_vld_q[CORE_LATENCY];
  assign pop  = resp_valid && resp_ready;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem_ch_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        mem_ch_q[wr_ptr_q]   <= tag_ch_q[CORE_LATENCY];
        mem_data_q[wr_ptr_q] <= core_out_value;
      end
    end
  end

  assign core_in_value = core_in_q;
  assign resp_valid    = fifo_cnt_q != '0;
  assign resp_ch       = resp_valid ? mem_ch_q[rd_ptr_q] : '0;
  assign resp_data     = resp_valid ? mem_data_q[rd_ptr_q] : '0;
  assign busy          = state_q != StIdle;

`ifdef FM_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [NUM_CH];
  logic [15:0] stall_cnt_q;
  logic        stall;

  assign stall = (state_q == StRun) && (|req_valid) && !credit_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (grant && win == ChW'(i) && grant_cnt_q[i] != 16'hFFFF) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      stat_grants[i*16 +: 16] = grant_cnt_q[i];
    end
  end
  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fm_core_scheduler.sv
// Scoreboard bench for fm_core_scheduler; FMCore modelled as an identity stage of latency 1.
module tb_fm_core_scheduler;
  localparam int NCH = 4;
  localparam int DW = 32;
  localparam int LAT = 1;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cfg_enable = 1'b0;
  logic resp_ready = 1'b0;
  logic [NCH-1:0] req_valid = '0;
  logic [NCH-1:0] req_ready;
  logic [NCH*DW-1:0] req_data = '0;
  logic [DW-1:0] core_in_value;
  logic [DW-1:0] core_out_value = '0;
  logic [DW-1:0] resp_data;
  logic resp_valid, busy;
  logic [1:0] resp_ch;
`ifdef FM_SCHED_STATS_EN
  logic [NCH*16-1:0] stat_grants;
  logic [15:0] stat_stall;
`endif

  always #5 clock = ~clock;

  fm_core_scheduler #(
    .NUM_CH(NCH), .DATA_W(DW), .CORE_LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .core_in_value(core_in_value), .core_out_value(core_out_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ch(resp_ch),
    .resp_data(resp_data), .busy(busy)
`ifdef FM_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  // FMCore stand-in: identity transfer, one cycle of latency, no stall.
  always @(posedge clock) core_out_value <= core_in_value;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] src_q [NCH][$];
  logic [DW-1:0] exp_q [NCH][$];
  int exp_order[$];
  int grants[NCH];
  int n_resp = 0;
  int outstanding = 0;
  int resp_mode = 0;  // 0: hold low, 1: always high, 2: low one cycle in four

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int ch, input logic [DW-1:0] d);
    src_q[ch].push_back(d);
    exp_q[ch].push_back(d);
    exp_order.push_back(ch);
  endtask

  task automatic flush();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      grants[c] = 0;
    end
    exp_order.delete();
    outstanding = 0;
    n_resp = 0;
  endtask

  function automatic bit all_done();
    bit d = (outstanding == 0);
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic do_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    cfg_enable = 1'b0;
    resp_mode = 0;
    flush();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic enable();
    @(posedge clock);
    #1 cfg_enable = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!all_done() && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(name, all_done(), 1);
  endtask

  // Driver: inputs change 1 time unit after the active edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      for (int c = 0; c < NCH; c++) begin
        req_valid[c] = src_q[c].size() > 0;
        req_data[c*DW +: DW] = (src_q[c].size() > 0) ? src_q[c][0] : '0;
      end
      resp_ready = (resp_mode == 1) || (resp_mode == 2 && (cyc % 4) != 0);
    end
  end

  // Monitor: handshakes sampled on the falling edge, where everything is settled.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (req_ready != '0) chk("req_ready_onehot", $onehot(req_ready), 1);
        for (int c = 0; c < NCH; c++) begin
          if (req_valid[c] && req_ready[c]) begin
            grants[c]++;
            outstanding++;
            if (src_q[c].size() > 0) void'(src_q[c].pop_front());
            chk("no_push_at_full", outstanding <= DEPTH, 1);
          end
        end
        if (resp_valid && resp_ready) begin
          n_resp++;
          outstanding--;
          if (exp_order.size() > 0) chk("resp_order", resp_ch, exp_order.pop_front());
          if ($isunknown(resp_ch) || exp_q[int'(resp_ch)].size() == 0) begin
            chk("resp_unexpected", {resp_ch, resp_data}, 0);
          end else begin
            chk($sformatf("resp_data_ch%0d", resp_ch), resp_data,
                exp_q[int'(resp_ch)].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, t0, t_empty, t_idle, v;
    real pi;
    pi = 3.14159265358979;

    // Reset values
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_core_in", core_in_value, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ch", resp_ch, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);

    // Single request on ch2: response three cycles after the transfer
    enable();
    resp_mode = 1;
    push_req(2, 32'h0010_0000);
    k = 0;
    do begin @(negedge clock); k++; end while (!(req_valid[2] && req_ready[2]) && k < 20);
    chk("single_grant_seen", req_ready, 4'b0100);
    t0 = cyc;
    @(negedge clock);
    chk("single_core_in", core_in_value, 32'h0010_0000);
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clock); k++; end
    chk("single_latency", cyc - t0, LAT + 2);
    chk("single_resp_ch", resp_ch, 2);
    wait_done(50, "single_done");

    // Fairness: 100 grants split evenly in strict rotation
    do_reset();
    enable();
    resp_mode = 1;
    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < NCH; c++) push_req(c, (32'(c) << 24) | 32'(i));
    end
    wait_done(400, "fair_done");
    for (int c = 0; c < NCH; c++) chk($sformatf("fair_grants_ch%0d", c), grants[c], 25);

    // Backpressure: exactly OUT_DEPTH grants while resp_ready is held low
    do_reset();
    enable();
    resp_mode = 0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NCH; c++) push_req(c, 32'hB000_0000 | (32'(c) << 8) | 32'(i));
    end
    repeat (20) @(negedge clock);
    chk("bp_grants", grants[0] + grants[1] + grants[2] + grants[3], DEPTH);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_resp_valid", resp_valid, 1);
    resp_mode = 1;
    wait_done(200, "bp_done");
    chk("bp_resp_count", n_resp, 12);

    // Drain: three in flight, enable dropped, remaining source data never granted
    do_reset();
    enable();
    resp_mode = 0;
    for (int i = 0; i < 5; i++) push_req(0, 32'hD000_0000 | 32'(i));
    k = 0;
    t0 = 0;
    while (t0 < 3 && k < 40) begin
      @(negedge clock);
      k++;
      if (req_valid[0] && req_ready[0]) t0++;
    end
    cfg_enable = 1'b0;
    repeat (10) @(negedge clock);
    chk("drain_no_new_grant", grants[0], 3);
    chk("drain_busy", busy, 1);
    src_q[0].delete();
    repeat (2) begin
      void'(exp_q[0].pop_back());
      void'(exp_order.pop_back());
    end
    resp_mode = 1;
    t_empty = -1;
    t_idle = -1;
    k = 0;
    while ((t_empty < 0 || t_idle < 0) && k < 50) begin
      @(negedge clock);
      k++;
      if (!resp_valid && t_empty < 0) t_empty = cyc;
      if (!busy && t_idle < 0) t_idle = cyc;
    end
    chk("drain_busy_fall", t_idle - t_empty, 1);
    chk("drain_resp_count", n_resp, 3);
    wait_done(20, "drain_done");

    // Asynchronous reset mid-burst
    do_reset();
    enable();
    resp_mode = 1;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NCH; c++) push_req(c, 32'hA000_0000 | (32'(c) << 8) | 32'(i));
    end
    repeat (6) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_core_in", core_in_value, 0);
    flush();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    for (int c = 0; c < NCH; c++) push_req(c, 32'hC000_0000 | 32'(c));
    k = 0;
    do begin @(negedge clock); k++; end while (req_ready == '0 && k < 20);
    chk("arst_first_grant", req_ready, 4'b0001);
    wait_done(50, "arst_done");

    // Sine stream on ch1 interleaved with a constant on ch3
    do_reset();
    enable();
    resp_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      v = $rtoi($floor(1048576.0 * $sin(2.0 * pi * i / 100.0) + 0.5));
      push_req(1, 32'(v));
      push_req(3, 32'h00AB_CDEF);
    end
    wait_done(20000, "sine_done");
    chk("sine_resp_count", n_resp, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
